frame_vga_reader: RTL and testbench
===================================

// Module: frame_vga_reader
// PURPOSE
//  Read side of the 12-bit frame-buffer RAM: VGA 640x480@60 timing generator and pixel fetcher.
//  Walks the full 800x525 raster and drives the RAM read address, one pixel per pixel tick.
//  Registers returned RAM data onto the 4:4:4 RGB pins, blanked outside the active window.
//  Sits between the frame RAM read port and the board VGA connector; the camera path owns the write port.
// PARAMETERS
//  CLK_DIV   4    system clocks per pixel tick (100 MHz -> 25 MHz); legal >= 2
//  H_TOTAL   800  clocks-per-line in pixel ticks; H_SYNC 96, H_BP 48, H_ACTIVE 640, H_FP 16
//  V_TOTAL   525  lines per frame; V_SYNC 2, V_BP 33, V_ACTIVE 480, V_FP 10
//  ADDR_W    19   RAM address width; DATA_W 12 pixel width {R[11:8],G[7:4],B[3:0]}
// PORTS
//  clk          in   1       system clock, all logic on posedge
//  rst_n        in   1       synchronous reset, active-low
//  display_en   in   1       1 = show RAM contents; sampled at frame start only
//  data_read    in   12      RAM read data, valid one clk after addr_read changes
//  addr_read    out  19      RAM read address = v_cnt*H_TOTAL + h_cnt
//  vga_r/g/b    out  4 each  pixel colour, 0 when blanked
//  hsync        out  1       horizontal sync, active-low
//  vsync        out  1       vertical sync, active-low
//  frame_start  out  1       one-clk pulse on the tick where h_cnt=0,v_cnt=0
// BEHAVIOUR
//  Interface: one clock (clk); reset rst_n synchronous, active-low.
//  Reset: pix_cnt=0, h_cnt=0, v_cnt=0, addr_read=0, rgb=0, hsync=1, vsync=1, frame_start=0, en_frame=0.
//  Tick: pix_cnt counts 0..CLK_DIV-1; tick = (pix_cnt==CLK_DIV-1). Nothing below advances without tick.
//  Raster, origin at start of sync: h 0..95 sync, 96..143 BP, 144..783 active, 784..799 FP;
//   v 0..1 sync, 2..34 BP, 35..514 active, 515..524 FP. Active RAM window 28000..411999 by construction.
//  Counters: on tick h_cnt++; h_cnt==H_TOTAL-1 -> h_cnt=0, v_cnt++; v_cnt==V_TOTAL-1 at line end -> v_cnt=0.
//  Address: incremental counter (no multiplier) registered on tick; equals v_cnt*H_TOTAL+h_cnt;
//   wraps H_TOTAL*V_TOTAL-1 (419999) -> 0 together with the raster.
//  Pipeline (stage 1, on tick k): addr_read, de_s1=(h,v active), hs_s1=(h<H_SYNC), vs_s1=(v<V_SYNC).
//  Stage 2 (on tick k+1): hsync=~hs_s1, vsync=~vs_s1, rgb = (de_s1 & en_frame) ? data_read : 0.
//   RAM data settles CLK_DIV-1 clks before capture; syncs and RGB stay mutually aligned, 1 pixel behind counters.
//  display_en: latched into en_frame on the tick where h_cnt=0,v_cnt=0; mid-frame changes ignored until next frame.
//   With en_frame=0 syncs keep running, RGB held 0, addr_read still walks.
//  frame_start: high exactly one clk, the clk of the tick entering h=0,v=0; not asserted by reset itself.
//  Outputs hold between ticks (change only on tick clks).
//  Reset mid-frame: all state to reset values on next edge, raster restarts at h=0,v=0; no partial-line recovery.
//  RAM holds data_read outside 28000..411999; block never relies on it there (de_s1=0 forces blank).
// TESTING
//  Reset: rst_n=0 for 3 clk -> addr_read=0, hsync=vsync=1, rgb=0, frame_start=0; first sync low 2 ticks (8 clk) after release.
//  Line timing: measure hsync -> period 3200 clk, low 384 clk; addr_read steps +1 every 4 clk.
//  Frame timing: vsync period 1,680,000 clk, low 6400 clk; addr_read 419999 -> 0 coincident with frame_start.
//  Pixel path with RAM model: preload 28144=0xABC, 28143=0xFFF, 28783=0x123, 28784=0x777, display_en=1 ->
//   first active pixel R=A,G=B,B=C, aligned with de; 0xFFF at h=143 and 0x777 at h=784 show as 0; 0x123 shown last.
//  display_en: drop to 0 at v=200 -> frame continues with video; next frame RGB=0 throughout, syncs unchanged; raise -> video returns next frame.
//  Reset mid-line at h=400,v=300 -> next edge outputs reset values; following frame timing matches frame-timing check.

Source files
------------

// File: rtl/frame_vga_reader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : frame_vga_reader_if
//  Description : Bundle between the VGA frame reader, the frame-RAM read port
//                and the board VGA connector.
//                master : the reader (drives address, colour, syncs)
//                slave  : RAM / connector side (drives data_read, display_en)
//  Signals     : display_en  - show RAM contents (sampled at frame start)
//                data_read   - RAM read data, one clk after addr_read
//                addr_read   - RAM read address
//                vga_r/g/b   - 4-bit colour channels, 0 when blanked
//                hsync/vsync - active-low syncs
//                frame_start - one-clk pulse at raster origin
//  Revision    : 1.0 - initial release
// ============================================================================
interface frame_vga_reader_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 12
);
    logic              display_en;
    logic [DATA_W-1:0] data_read;
    logic [ADDR_W-1:0] addr_read;
    logic [3:0]        vga_r;
    logic [3:0]        vga_g;
    logic [3:0]        vga_b;
    logic              hsync;
    logic              vsync;
    logic              frame_start;

    modport master (
        input  display_en, data_read,
        output addr_read, vga_r, vga_g, vga_b, hsync, vsync, frame_start
    );

    modport slave (
        output display_en, data_read,
        input  addr_read, vga_r, vga_g, vga_b, hsync, vsync, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/frame_vga_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : frame_vga_reader
//  Description : Read side of the 12-bit frame-buffer RAM. Generates VGA
//                640x480@60 timing, walks the whole H_TOTAL x V_TOTAL raster
//                driving the RAM read address one pixel per pixel tick, and
//                registers returned data onto the 4:4:4 RGB pins, blanked
//                outside the active window.
//  Ports       : clk   - system clock, all logic on posedge
//                rst_n - synchronous reset, active-low
//                bus   - frame_vga_reader_if.master (RAM read port, VGA pins,
//                        display_en, frame_start)
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_vga_reader #(
    parameter int CLK_DIV  = 4,     // system clocks per pixel tick, >= 2
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 12     // {R[11:8],G[7:4],B[3:0]}
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    frame_vga_reader_if.master bus
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int P_W     = $clog2(CLK_DIV);
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [P_W-1:0] c_PIX_LAST  = P_W'(CLK_DIV - 1);
    localparam logic [H_W-1:0] c_H_LAST    = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] c_H_SYNC_E  = H_W'(H_SYNC);
    localparam logic [H_W-1:0] c_H_ACT_B   = H_W'(H_SYNC + H_BP);
    localparam logic [H_W-1:0] c_H_ACT_E   = H_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [V_W-1:0] c_V_LAST    = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] c_V_SYNC_E  = V_W'(V_SYNC);
    localparam logic [V_W-1:0] c_V_ACT_B   = V_W'(V_SYNC + V_BP);
    localparam logic [V_W-1:0] c_V_ACT_E   = V_W'(V_SYNC + V_BP + V_ACTIVE);

    logic [P_W-1:0]    r_pix_cnt;
    logic [H_W-1:0]    r_h_cnt;
    logic [V_W-1:0]    r_v_cnt;
    logic [ADDR_W-1:0] r_addr_read;
    logic              r_de_s1;
    logic              r_hs_s1;
    logic              r_vs_s1;
    logic              r_hsync;
    logic              r_vsync;
    logic [DATA_W-1:0] r_rgb;
    logic              r_en_frame;
    logic              r_frame_start;

    logic w_tick;
    logic w_line_end;
    logic w_origin;
    logic w_h_act;
    logic w_v_act;

    assign w_tick     = (r_pix_cnt == c_PIX_LAST);
    assign w_line_end = (r_h_cnt == c_H_LAST);
    assign w_origin   = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_h_act    = (r_h_cnt >= c_H_ACT_B) && (r_h_cnt < c_H_ACT_E);
    assign w_v_act    = (r_v_cnt >= c_V_ACT_B) && (r_v_cnt < c_V_ACT_E);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pix_cnt     <= '0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_addr_read   <= '0;
            r_de_s1       <= 1'b0;
            r_hs_s1       <= 1'b0;
            r_vs_s1       <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_rgb         <= '0;
            r_en_frame    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_pix_cnt     <= w_tick ? '0 : r_pix_cnt + 1'b1;

            if (w_tick) begin
                // Raster counters
                if (w_line_end) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + 1'b1;
                end else begin
                    r_h_cnt <= r_h_cnt + 1'b1;
                end

                // Stage 1: address and timing flags for the current position.
                // Positions are visited in raster order, so the address is a
                // plain incrementer restarted at the origin.
                r_addr_read <= w_origin ? '0 : r_addr_read + 1'b1;
                r_de_s1     <= w_h_act && w_v_act;
                r_hs_s1     <= (r_h_cnt < c_H_SYNC_E);
                r_vs_s1     <= (r_v_cnt < c_V_SYNC_E);

                // Stage 2: RAM data for the stage-1 address has been stable
                // since one clk after it was issued; syncs move with it.
                r_hsync <= ~r_hs_s1;
                r_vsync <= ~r_vs_s1;
                r_rgb   <= (r_de_s1 && r_en_frame) ? bus.data_read : '0;

                // display_en only takes effect on frame boundaries
                if (w_origin) begin
                    r_en_frame    <= bus.display_en;
                    r_frame_start <= 1'b1;
                end
            end
        end
    end

    assign bus.addr_read   = r_addr_read;
    assign bus.vga_r       = r_rgb[11:8];
    assign bus.vga_g       = r_rgb[7:4];
    assign bus.vga_b       = r_rgb[3:0];
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_frame_vga_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_frame_vga_reader
//  Description : Directed self-checking bench. u_full uses the real 800x525
//                raster for reset, line and vsync-low timing; u_small uses a
//                14x7 raster (active h 6..11, v 3..5) with a RAM model for
//                frame timing, address wrap, pixel path, display_en and
//                mid-frame reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_vga_reader;

    logic clk = 1'b0;
    logic rst_n_full;
    logic rst_n_small;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] mem [0:127];

    frame_vga_reader_if bus_full ();
    frame_vga_reader_if bus_small ();

    frame_vga_reader u_full (
        .clk   (clk),
        .rst_n (rst_n_full),
        .bus   (bus_full)
    );

    frame_vga_reader #(
        .CLK_DIV (4),
        .H_SYNC  (4), .H_BP (2), .H_ACTIVE (6), .H_FP (2),
        .V_SYNC  (2), .V_BP (1), .V_ACTIVE (3), .V_FP (1)
    ) u_small (
        .clk   (clk),
        .rst_n (rst_n_small),
        .bus   (bus_small)
    );

    always #5 clk = ~clk;

    // RAM model: data one clk after address
    always @(posedge clk) bus_small.data_read <= mem[bus_small.addr_read[6:0]];

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus_full.hsync;
            1:       return bus_full.vsync;
            2:       return bus_small.hsync;
            3:       return bus_small.vsync;
            default: return 1'b0;
        endcase
    endfunction

    // Count negedges until the selected signal equals lvl
    task automatic wait_lvl(input int sel, input logic lvl, input int max, output int n);
        n = 0;
        while (sig(sel) !== lvl && n < max) begin
            @(negedge clk);
            n++;
        end
        if (sig(sel) !== lvl) chk("wait_timeout", n, -1);
    endtask

    task automatic wait_addr(input int addr);
        int n = 0;
        while (int'(bus_small.addr_read) != addr && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (int'(bus_small.addr_read) != addr) chk("addr_timeout", int'(bus_small.addr_read), addr);
    endtask

    // Waits for addr, then samples the pixel produced for it one tick later
    task automatic pix_at(input string tag, input int addr, input int exp_rgb, input int exp_hs);
        wait_addr(addr);
        repeat (4) @(negedge clk);
        chk({tag, "_rgb"}, int'({bus_small.vga_r, bus_small.vga_g, bus_small.vga_b}), exp_rgb);
        chk({tag, "_hs"}, int'(bus_small.hsync), exp_hs);
    endtask

    // Called on the negedge right after rst_n_small is released
    task automatic small_timing(input string tag);
        int a, b, c, d, e;
        wait_lvl(3, 1'b0, 100, a);
        chk({tag, "_first_vs_low"}, a, 8);
        wait_lvl(3, 1'b1, 1000, b);
        chk({tag, "_vs_low"}, b, 112);
        wait_lvl(3, 1'b0, 1000, c);
        chk({tag, "_vs_period"}, b + c, 392);
        wait_lvl(2, 1'b1, 100, d);
        chk({tag, "_hs_low"}, d, 16);
        wait_lvl(2, 1'b0, 100, e);
        chk({tag, "_hs_period"}, d + e, 56);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, lo;
        rst_n_full  = 1'b0;
        rst_n_small = 1'b0;
        bus_full.display_en  = 1'b0;
        bus_full.data_read   = 12'hFFF;
        bus_small.display_en = 1'b1;
        for (int i = 0; i < 128; i++) mem[i] = 12'h5A5;
        mem[47] = 12'hFFF;   // h=5 (back porch)
        mem[48] = 12'hABC;   // first active pixel
        mem[53] = 12'h123;   // last active pixel of the line
        mem[54] = 12'h777;   // h=12 (front porch)

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        chk("rst_addr", int'(bus_full.addr_read), 0);
        chk("rst_hsync", int'(bus_full.hsync), 1);
        chk("rst_vsync", int'(bus_full.vsync), 1);
        chk("rst_rgb", int'({bus_full.vga_r, bus_full.vga_g, bus_full.vga_b}), 0);
        chk("rst_fs", int'(bus_full.frame_start), 0);

        // ---------------- full raster: start-up and line timing ----------------
        rst_n_full = 1'b1;
        repeat (3) @(negedge clk);
        chk("fs_c3", int'(bus_full.frame_start), 0);
        @(negedge clk);
        chk("fs_c4", int'(bus_full.frame_start), 1);
        chk("addr_c4", int'(bus_full.addr_read), 0);
        @(negedge clk);
        chk("fs_c5", int'(bus_full.frame_start), 0);
        wait_lvl(0, 1'b0, 20, n);
        chk("full_first_hs_low", 5 + n, 8);
        chk("full_first_vs", int'(bus_full.vsync), 0);
        chk("addr_c8", int'(bus_full.addr_read), 1);
        repeat (3) @(negedge clk);
        chk("addr_c11", int'(bus_full.addr_read), 1);
        @(negedge clk);
        chk("addr_c12", int'(bus_full.addr_read), 2);
        wait_lvl(0, 1'b1, 1000, n);
        lo = 4 + n;
        chk("full_hs_low", lo, 384);
        wait_lvl(0, 1'b0, 5000, n);
        chk("full_hs_period", lo + n, 3200);
        wait_lvl(1, 1'b1, 10000, n);
        chk("full_vs_low", 3200 + n, 6400);
        chk("full_rgb_dis", int'({bus_full.vga_r, bus_full.vga_g, bus_full.vga_b}), 0);

        // ---------------- small raster: frame timing ----------------
        rst_n_small = 1'b1;
        small_timing("s0");

        // address wrap coincident with frame_start
        wait_addr(97);
        n = 0;
        while (int'(bus_small.addr_read) == 97 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("wrap_addr", int'(bus_small.addr_read), 0);
        chk("wrap_fs", int'(bus_small.frame_start), 1);
        @(negedge clk);
        chk("wrap_fs_pulse", int'(bus_small.frame_start), 0);

        // ---------------- pixel path ----------------
        pix_at("p_h3", 45, 12'h000, 0);
        pix_at("p_h4", 46, 12'h000, 1);
        pix_at("p_bp", 47, 12'h000, 1);
        pix_at("p_first", 48, 12'hABC, 1);
        pix_at("p_last", 53, 12'h123, 1);
        pix_at("p_fp", 54, 12'h000, 1);
        pix_at("p_row4", 62, 12'h5A5, 1);
        pix_at("p_vfp", 90, 12'h000, 1);

        // ---------------- display_en ----------------
        pix_at("en_a_first", 48, 12'hABC, 1);
        bus_small.display_en = 1'b0;             // mid-frame drop
        pix_at("en_a_cont", 62, 12'h5A5, 1);
        pix_at("en_b_hs", 45, 12'h000, 0);
        pix_at("en_b_off", 48, 12'h000, 1);
        bus_small.display_en = 1'b1;             // mid-frame raise
        pix_at("en_b_still_off", 62, 12'h000, 1);
        pix_at("en_c_on", 48, 12'hABC, 1);

        // ---------------- reset mid-frame ----------------
        wait_addr(60);
        rst_n_small = 1'b0;
        @(negedge clk);
        chk("mrst_addr", int'(bus_small.addr_read), 0);
        chk("mrst_hsync", int'(bus_small.hsync), 1);
        chk("mrst_vsync", int'(bus_small.vsync), 1);
        chk("mrst_rgb", int'({bus_small.vga_r, bus_small.vga_g, bus_small.vga_b}), 0);
        chk("mrst_fs", int'(bus_small.frame_start), 0);
        repeat (2) @(negedge clk);
        rst_n_small = 1'b1;
        small_timing("s1");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
